bsw_score_merge: RTL

BSW_SCORE_MERGE -- requirements
Module: bsw_score_merge

---
 rtl/bsw_score_merge_pkg.sv | 19 +
 rtl/bsw_rr_arbiter.sv | 47 ++++
 rtl/bsw_score_merge.sv | 114 +++++++++++
 3 files changed

// File: rtl/bsw_score_merge_pkg.sv
// Shared definitions for the bsw score path: score word width, arbitration
// modes and the channel-tag sizing helper.
package bsw_score_merge_pkg;

  localparam int BSW_SCORE_W = 48;

  typedef enum logic {
    ARB_ROUND_ROBIN = 1'b0,
    ARB_FIXED_PRIO  = 1'b1
  } arb_mode_e;

  // Tag width for a given channel count; a single channel still needs one bit.
  function automatic int tag_width(input int nch);
    int w;
    w = $clog2(nch);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/bsw_rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from ptr, or fixed priority
// (channel 0 highest) by forcing the search start to zero.
module bsw_rr_arbiter
  import bsw_score_merge_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int mode = 0,
  parameter int TAGW = tag_width(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [TAGW-1:0] ptr,
  output logic [NCH-1:0]  grant,
  output logic [TAGW-1:0] grant_idx,
  output logic            grant_any
);

  logic [TAGW-1:0] start;
  logic [NCH-1:0]  req_rot;

  always_comb begin
    start = (mode == int'(ARB_FIXED_PRIO)) ? '0 : ptr;
  end

  // Rotate so that bit 0 of req_rot is the channel at the search start.
  always_comb begin
    req_rot = NCH'({req, req} >> start);
  end

  always_comb begin
    int pos;
    pos       = 0;
    grant_any = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        pos       = k;
        grant_any = 1'b1;
      end
    end
    pos = pos + int'(start);
    if (pos >= NCH) begin
      pos = pos - NCH;
    end
    grant_idx = TAGW'(pos);
    grant     = grant_any ? (NCH'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/bsw_score_merge.sv
// Merges NCH first-word-fall-through score channels into one tagged stream
// through a 2-entry output buffer; one word per cycle when the sink keeps up.
module bsw_score_merge
  import bsw_score_merge_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int width = BSW_SCORE_W,
  parameter int mode  = 0,
  parameter int TAGW  = tag_width(NCH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCH*width-1:0]   s_in,
  input  logic [NCH-1:0]         v_in,
  output logic [NCH-1:0]         ack_in,
  output logic [TAGW+width-1:0]  s_out,
  input  logic                   v_out,
  output logic                   ack_out,
  output logic [1:0]             count
);

  localparam int EW = TAGW + width;

  logic [EW-1:0]    entry0;
  logic [EW-1:0]    entry1;
  logic [TAGW-1:0]  ptr;
  logic [NCH-1:0]   req;
  logic [NCH-1:0]   grant;
  logic [TAGW-1:0]  grant_idx;
  logic             grant_any;
  logic             room;
  logic             push;
  logic [width-1:0] push_score;
  logic [EW-1:0]    push_word;

  assign ack_out = (count != 2'd0) && v_out;
  assign room    = (count != 2'd2) || ack_out;

  // Gating with rst keeps ack_in low during reset without waiting for an edge.
  assign req = (rst && room) ? v_in : '0;

  bsw_rr_arbiter #(
    .NCH  (NCH),
    .mode (mode),
    .TAGW (TAGW)
  ) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign ack_in = grant;
  assign push   = grant_any;

  always_comb begin
    push_score = '0;
    for (int i = 0; i < NCH; i++) begin
      if (grant[i]) begin
        push_score = s_in[i*width +: width];
      end
    end
  end

  assign push_word = {grant_idx, push_score};
  assign s_out     = entry0;

  // entry0 is always the head; entry1 only holds data when count is 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= 2'd0;
      ptr    <= '0;
    end else begin
      case ({push, ack_out})
        2'b10: begin
          if (count == 2'd0) begin
            entry0 <= push_word;
          end else begin
            entry1 <= push_word;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          entry1 <= '0;
          count  <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            entry0 <= push_word;
          end else begin
            entry0 <= entry1;
            entry1 <= push_word;
          end
        end
        default: begin
        end
      endcase
      if (push && (mode == int'(ARB_ROUND_ROBIN))) begin
        ptr <= (grant_idx == TAGW'(NCH - 1)) ? '0 : grant_idx + TAGW'(1);
      end
    end
  end

  assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == 2'd2) && !ack_out));

  assert property (@(posedge clk) disable iff (!rst)
    $onehot0(ack_in) && ((ack_in & ~v_in) == '0));

endmodule
